// File: rtl/write_gather_pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wgp_pkg : AXI constants, drain FSM state type and width helper for the
//           write_gather_pipe block.                                 Rev 1.0
// ----------------------------------------------------------------------------
package wgp_pkg;

  localparam logic [1:0] c_burst_incr = 2'b01;
  localparam logic [1:0] c_resp_okay  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } drain_state_e;

  // Index width that stays legal (>= 1 bit) for single-entry ranges.
  function automatic int wgp_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/write_gather_pipe_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// write_gather_pipe_if : AXI4 write-only channel bundle (AW, W, B) between the
//                        gather pipe (master) and the interconnect. Rev 1.0
// ----------------------------------------------------------------------------
interface write_gather_pipe_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64
);

  logic [AXI_ADDR_W-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [AXI_DATA_W-1:0]   WDATA;
  logic [AXI_DATA_W/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;

  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY
  );

endinterface
`default_nettype wire

// File: rtl/write_gather_pipe_line_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wgp_line_buffer : DEPTH-line circular store of gathered CPU words with a
//                   word write port and a beat read port.          Rev 1.0
// ----------------------------------------------------------------------------
module wgp_line_buffer
  import wgp_pkg::*;
#(
  parameter int  DATA_W      = 64,
  parameter int  BURST_BYTES = 32,
  parameter int  DEPTH       = 4,
  localparam int WORDS       = BURST_BYTES / 4,
  localparam int BEATS       = BURST_BYTES * 8 / DATA_W,
  localparam int WPB         = DATA_W / 32,
  localparam int PTR_W       = wgp_width(DEPTH),
  localparam int WIDX_W      = wgp_width(WORDS),
  localparam int BEAT_W      = wgp_width(BEATS),
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_i,
  input  logic [31:0]       wr_data_i,
  input  logic              flush_i,
  input  logic              pop_i,
  input  logic [BEAT_W-1:0] rd_beat_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              stall_o,
  output logic              commit_o,
  output logic              partial_o
);

  logic [31:0]       mem_q [DEPTH][WORDS];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, tail_nxt;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic              pad_q, pad_d;
  logic              accept, line_full, commit;

  // While a pad commit is pending the tail slot is spoken for, so a store
  // only fits if a further slot is free.
  assign stall_o   = (count_q == CNT_W'(DEPTH)) ||
                     (pad_q && (count_q == CNT_W'(DEPTH - 1)));
  assign accept    = wr_i && !stall_o;
  assign line_full = (widx_q == WIDX_W'(WORDS - 1));
  assign commit    = pad_q || (accept && line_full);
  assign tail_nxt  = tail_q + PTR_W'(1);

  always_comb begin
    widx_d = widx_q;
    if (pad_q) begin
      widx_d = accept ? WIDX_W'(1) : '0;
    end else if (accept) begin
      widx_d = line_full ? '0 : widx_q + WIDX_W'(1);
    end
  end

  assign pad_d  = flush_i && (widx_d != '0);
  assign tail_d = commit ? tail_nxt : tail_q;
  assign head_d = pop_i ? head_q + PTR_W'(1) : head_q;

  always_comb begin
    count_d = count_q;
    if (commit && !pop_i) begin
      count_d = count_q + CNT_W'(1);
    end else if (!commit && pop_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      widx_q  <= '0;
      pad_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      pad_q   <= pad_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pad_q) begin
      for (int w = 0; w < WORDS; w++) begin
        if (WIDX_W'(w) >= widx_q) begin
          mem_q[tail_q][WIDX_W'(w)] <= '0;
        end
      end
      if (accept) begin
        mem_q[tail_nxt][WIDX_W'(0)] <= wr_data_i;
      end
    end else if (accept) begin
      mem_q[tail_q][widx_q] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < WPB; k++) begin
      rd_data_o[32*k +: 32] = mem_q[head_q][WIDX_W'(int'(rd_beat_i) * WPB + k)];
    end
  end

  assign count_o   = count_q;
  assign commit_o  = commit;
  assign partial_o = (widx_q != '0) || pad_q;

endmodule
`default_nettype wire

// File: rtl/write_gather_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// write_gather_pipe : gathers CPU stores into lines and drains each line as
// one AXI4 INCR burst. Optional WGP_WRAP_EN: circular pointer wrap. Rev 1.0
// ----------------------------------------------------------------------------
module write_gather_pipe
  import wgp_pkg::*;
#(
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_DATA_W  = 64,
  parameter int BURST_BYTES = 32,
  parameter int DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           CPUWriteData,
  input  logic                  CPUWrite,
  output logic                  CPUStall,
  input  logic                  Flush,
  input  logic [AXI_ADDR_W-1:0] FifoBase,
  input  logic [AXI_ADDR_W-1:0] FifoEnd,
  input  logic                  WritePtrLoad,
  input  logic [AXI_ADDR_W-1:0] WritePtrIn,
  output logic [AXI_ADDR_W-1:0] WritePtr,
  output logic                  Wrapped,
  output logic                  BusError,
  output logic                  Busy,
  write_gather_pipe_if.master   axi
);

  localparam int BEATS  = BURST_BYTES * 8 / AXI_DATA_W;
  localparam int BEAT_W = wgp_width(BEATS);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  drain_state_e          state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [AXI_ADDR_W-1:0] ptr_q, ptr_d, ptr_adv, ptr_ret;
  logic                  buserr_q, buserr_d;
  logic [CNT_W-1:0]      count;
  logic [AXI_DATA_W-1:0] rd_data;
  logic                  commit, partial, retire, awvalid, wvalid, last_beat;

  wgp_line_buffer #(
    .DATA_W      (AXI_DATA_W),
    .BURST_BYTES (BURST_BYTES),
    .DEPTH       (DEPTH)
  ) u_line_buffer (
    .clk       (clk),
    .resetn    (resetn),
    .wr_i      (CPUWrite),
    .wr_data_i (CPUWriteData),
    .flush_i   (Flush),
    .pop_i     (retire),
    .rd_beat_i (beat_q),
    .rd_data_o (rd_data),
    .count_o   (count),
    .stall_o   (CPUStall),
    .commit_o  (commit),
    .partial_o (partial)
  );

  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  // IDLE looks at the commit strobe so a fresh line raises AWVALID one cycle
  // after its commit edge; RESP always returns through IDLE (one bubble).
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: if ((count != '0) || commit) state_d = ST_ADDR;
      ST_ADDR: if (axi.AWREADY) begin
        state_d = ST_DATA;
        beat_d  = '0;
      end
      ST_DATA: if (axi.WREADY) begin
        if (last_beat) state_d = ST_RESP;
        else           beat_d  = beat_q + BEAT_W'(1);
      end
      ST_RESP: if (axi.BVALID) begin
        state_d = ST_IDLE;
        retire  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ptr_adv = ptr_q + AXI_ADDR_W'(BURST_BYTES);

`ifdef WGP_WRAP_EN
  logic wrap_hit, wrapped_q;
  assign wrap_hit = (ptr_adv >= FifoEnd);
  assign ptr_ret  = wrap_hit ? FifoBase : ptr_adv;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wrapped_q <= 1'b0;
    else         wrapped_q <= retire && wrap_hit;
  end
  assign Wrapped = wrapped_q;
`else
  logic unused_fifo_bounds;
  assign unused_fifo_bounds = ^{FifoBase, FifoEnd};
  assign ptr_ret = ptr_adv;
  assign Wrapped = 1'b0;
`endif

  always_comb begin
    ptr_d    = ptr_q;
    buserr_d = buserr_q;
    if (retire) begin
      ptr_d = ptr_ret;
      if (axi.BRESP != c_resp_okay) buserr_d = 1'b1;
    end else if (WritePtrLoad && !Busy) begin
      ptr_d    = WritePtrIn;
      buserr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      ptr_q    <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      ptr_q    <= ptr_d;
      buserr_q <= buserr_d;
    end
  end

  assign WritePtr = ptr_q;
  assign BusError = buserr_q;
  assign Busy     = (count != '0) || partial || (state_q != ST_IDLE);

  // Payload fields are zeroed outside their valid phase so every output
  // reads 0 while reset is asserted.
  assign awvalid     = (state_q == ST_ADDR);
  assign wvalid      = (state_q == ST_DATA);
  assign axi.AWVALID = awvalid;
  assign axi.AWADDR  = awvalid ? ptr_q : '0;
  assign axi.AWLEN   = awvalid ? 8'(BEATS - 1) : '0;
  assign axi.AWSIZE  = awvalid ? 3'($clog2(AXI_DATA_W / 8)) : '0;
  assign axi.AWBURST = awvalid ? c_burst_incr : '0;
  assign axi.WVALID  = wvalid;
  assign axi.WDATA   = wvalid ? rd_data : '0;
  assign axi.WSTRB   = wvalid ? '1 : '0;
  assign axi.WLAST   = wvalid && last_beat;
  assign axi.BREADY  = (state_q == ST_RESP);

endmodule
`default_nettype wire

// File: tb/tb_write_gather_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_write_gather_pipe : directed self-checking bench for write_gather_pipe
// (default 64-bit data, 32-byte lines, DEPTH 4).                     Rev 1.0
// ----------------------------------------------------------------------------
module tb_write_gather_pipe;

  localparam int AW = 32;
  localparam int DW = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] CPUWriteData = '0;
  logic        CPUWrite = 1'b0;
  logic        Flush = 1'b0;
  logic        WritePtrLoad = 1'b0;
  logic [31:0] WritePtrIn = '0;
  logic [31:0] FifoBase = '0;
  logic [31:0] FifoEnd = 32'hFFFF_0000;
  logic        CPUStall, Wrapped, BusError, Busy;
  logic [31:0] WritePtr;

  logic        aw_en = 1'b0;
  logic        w_en = 1'b1;
  logic [1:0]  bresp_cfg = 2'b00;
  logic        bvalid_q;

  int total = 0;
  int bad = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, wrap_cnt = 0;
  logic [31:0] aw_addr_log  [64];
  logic [7:0]  aw_len_log   [64];
  logic [2:0]  aw_size_log  [64];
  logic [1:0]  aw_burst_log [64];
  logic [63:0] w_data_log   [256];
  logic [7:0]  w_strb_log   [256];
  logic        w_last_log   [256];

  always #5 clk = ~clk;

  write_gather_pipe_if #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW)) axi_if ();

  assign axi_if.AWREADY = aw_en;
  assign axi_if.WREADY  = w_en;
  assign axi_if.BVALID  = bvalid_q;
  assign axi_if.BRESP   = bvalid_q ? bresp_cfg : 2'b00;

  write_gather_pipe #(
    .AXI_ADDR_W (AW),
    .AXI_DATA_W (DW),
    .BURST_BYTES(32),
    .DEPTH      (4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .CPUWriteData (CPUWriteData),
    .CPUWrite     (CPUWrite),
    .CPUStall     (CPUStall),
    .Flush        (Flush),
    .FifoBase     (FifoBase),
    .FifoEnd      (FifoEnd),
    .WritePtrLoad (WritePtrLoad),
    .WritePtrIn   (WritePtrIn),
    .WritePtr     (WritePtr),
    .Wrapped      (Wrapped),
    .BusError     (BusError),
    .Busy         (Busy),
    .axi          (axi_if)
  );

  // Write-response responder: one B beat after each WLAST handshake.
  always @(posedge clk or negedge resetn) begin
    if (!resetn)                                              bvalid_q <= 1'b0;
    else if (axi_if.WVALID && axi_if.WREADY && axi_if.WLAST)  bvalid_q <= 1'b1;
    else if (bvalid_q && axi_if.BREADY)                       bvalid_q <= 1'b0;
  end

  always @(posedge clk) begin
    if (axi_if.AWVALID && axi_if.AWREADY) begin
      aw_addr_log[aw_cnt % 64]  <= axi_if.AWADDR;
      aw_len_log[aw_cnt % 64]   <= axi_if.AWLEN;
      aw_size_log[aw_cnt % 64]  <= axi_if.AWSIZE;
      aw_burst_log[aw_cnt % 64] <= axi_if.AWBURST;
      aw_cnt <= aw_cnt + 1;
    end
    if (axi_if.WVALID && axi_if.WREADY) begin
      w_data_log[w_cnt % 256] <= axi_if.WDATA;
      w_strb_log[w_cnt % 256] <= axi_if.WSTRB;
      w_last_log[w_cnt % 256] <= axi_if.WLAST;
      w_cnt <= w_cnt + 1;
    end
    if (axi_if.BVALID && axi_if.BREADY) b_cnt <= b_cnt + 1;
    if (Wrapped) wrap_cnt <= wrap_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] d);
    CPUWrite     = 1'b1;
    CPUWriteData = d;
    tick();
    CPUWrite     = 1'b0;
  endtask

  task automatic load_ptr(input logic [31:0] p);
    WritePtrLoad = 1'b1;
    WritePtrIn   = p;
    tick();
    WritePtrLoad = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Busy && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 128'(n < 300), 128'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ab, wb, bb, wr0, n;

    // Reset state
    repeat (3) tick();
    chk("rst_writeptr", 128'(WritePtr), 128'(0));
    chk("rst_busy", 128'(Busy), 128'(0));
    chk("rst_stall", 128'(CPUStall), 128'(0));
    chk("rst_awvalid", 128'(axi_if.AWVALID), 128'(0));
    resetn = 1'b1;
    tick();
    load_ptr(32'h1000);
    chk("load_ptr", 128'(WritePtr), 128'(32'h1000));

    // One full line of stores -> one burst
    aw_en = 1'b1;
    ab = aw_cnt; wb = w_cnt;
    for (int k = 1; k <= 8; k++) store(32'(k));
    chk("t1_awvalid_after_commit", 128'(axi_if.AWVALID), 128'(1));
    chk("t1_awaddr_live", 128'(axi_if.AWADDR), 128'(32'h1000));
    wait_idle("t1_idle_timeout");
    chk("t1_bursts", 128'(aw_cnt - ab), 128'(1));
    chk("t1_awaddr", 128'(aw_addr_log[ab]), 128'(32'h1000));
    chk("t1_awlen", 128'(aw_len_log[ab]), 128'(3));
    chk("t1_awsize", 128'(aw_size_log[ab]), 128'(3));
    chk("t1_awburst", 128'(aw_burst_log[ab]), 128'(1));
    chk("t1_beats", 128'(w_cnt - wb), 128'(4));
    chk("t1_beat0", 128'(w_data_log[wb]), 128'(64'h00000002_00000001));
    chk("t1_beat3", 128'(w_data_log[wb+3]), 128'(64'h00000008_00000007));
    chk("t1_wstrb", 128'(w_strb_log[wb]), 128'(8'hFF));
    chk("t1_wlast0", 128'(w_last_log[wb]), 128'(0));
    chk("t1_wlast3", 128'(w_last_log[wb+3]), 128'(1));
    chk("t1_writeptr", 128'(WritePtr), 128'(32'h1020));

    // Fill with AWREADY low: stall at 32 stores, 33..40 dropped
    aw_en = 1'b0;
    ab = aw_cnt; wb = w_cnt;
    for (int k = 1; k <= 40; k++) begin
      store(32'h100 + 32'(k));
      if (k == 31) chk("t2_stall_before_full", 128'(CPUStall), 128'(0));
      if (k == 32) chk("t2_stall_at_full", 128'(CPUStall), 128'(1));
    end
    chk("t2_stall_held", 128'(CPUStall), 128'(1));
    chk("t2_awvalid_held", 128'(axi_if.AWVALID), 128'(1));
    chk("t2_awaddr_held", 128'(axi_if.AWADDR), 128'(32'h1020));
    aw_en = 1'b1;
    bb = b_cnt; n = 0;
    while (b_cnt == bb && n < 100) begin
      tick();
      n++;
    end
    chk("t2_first_b_timeout", 128'(n < 100), 128'(1));
    chk("t2_stall_released", 128'(CPUStall), 128'(0));
    wait_idle("t2_idle_timeout");
    chk("t2_bursts", 128'(aw_cnt - ab), 128'(4));
    chk("t2_awaddr3", 128'(aw_addr_log[ab+3]), 128'(32'h1080));
    chk("t2_line3_beat0", 128'(w_data_log[wb+12]), 128'(64'h0000011A_00000119));
    chk("t2_line3_beat3", 128'(w_data_log[wb+15]), 128'(64'h00000120_0000011F));
    chk("t2_writeptr", 128'(WritePtr), 128'(32'h10A0));

    // Flush with an empty partial line is ignored
    ab = aw_cnt;
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    tick();
    chk("t3_flush_empty_busy", 128'(Busy), 128'(0));
    chk("t3_flush_empty_bursts", 128'(aw_cnt - ab), 128'(0));

    // Partial line: third store coincides with Flush, remainder zero-padded
    ab = aw_cnt; wb = w_cnt;
    store(32'hA1);
    store(32'hA2);
    CPUWrite = 1'b1; CPUWriteData = 32'hA3; Flush = 1'b1;
    tick();
    CPUWrite = 1'b0; Flush = 1'b0;
    wait_idle("t3_idle_timeout");
    chk("t3_bursts", 128'(aw_cnt - ab), 128'(1));
    chk("t3_beat0", 128'(w_data_log[wb]), 128'(64'h000000A2_000000A1));
    chk("t3_beat1", 128'(w_data_log[wb+1]), 128'(64'h00000000_000000A3));
    chk("t3_beat2", 128'(w_data_log[wb+2]), 128'(64'h0));
    chk("t3_beat3", 128'(w_data_log[wb+3]), 128'(64'h0));
    chk("t3_writeptr", 128'(WritePtr), 128'(32'h10C0));

    // SLVERR: sticky BusError, pointer still advances
    bresp_cfg = 2'b10;
    for (int k = 1; k <= 8; k++) store(32'h30 + 32'(k));
    wait_idle("t4_idle_timeout");
    bresp_cfg = 2'b00;
    chk("t4_buserr_set", 128'(BusError), 128'(1));
    chk("t4_writeptr", 128'(WritePtr), 128'(32'h10E0));
    aw_en = 1'b0;
    for (int k = 1; k <= 8; k++) store(32'h60 + 32'(k));
    chk("t4_busy", 128'(Busy), 128'(1));
    load_ptr(32'h3000);
    chk("t4_load_while_busy_ptr", 128'(WritePtr), 128'(32'h10E0));
    chk("t4_load_while_busy_err", 128'(BusError), 128'(1));
    aw_en = 1'b1;
    wait_idle("t4b_idle_timeout");
    chk("t4_okay_keeps_err", 128'(BusError), 128'(1));
    chk("t4_writeptr2", 128'(WritePtr), 128'(32'h1100));
    load_ptr(32'h2000);
    chk("t4_load_clears_err", 128'(BusError), 128'(0));
    chk("t4_load_ptr", 128'(WritePtr), 128'(32'h2000));

    // Circular region 0x1000..0x1040 starting at 0x1020
    FifoBase = 32'h1000;
    FifoEnd  = 32'h1040;
    load_ptr(32'h1020);
    ab = aw_cnt; wr0 = wrap_cnt;
    for (int k = 1; k <= 16; k++) store(32'h70 + 32'(k));
    wait_idle("t5_idle_timeout");
    chk("t5_bursts", 128'(aw_cnt - ab), 128'(2));
    chk("t5_awaddr0", 128'(aw_addr_log[ab]), 128'(32'h1020));
`ifdef WGP_WRAP_EN
    chk("t5_awaddr1", 128'(aw_addr_log[ab+1]), 128'(32'h1000));
    chk("t5_writeptr", 128'(WritePtr), 128'(32'h1020));
    chk("t5_wrapped", 128'(wrap_cnt - wr0), 128'(1));
`else
    chk("t5_awaddr1", 128'(aw_addr_log[ab+1]), 128'(32'h1040));
    chk("t5_writeptr", 128'(WritePtr), 128'(32'h1060));
    chk("t5_wrapped", 128'(wrap_cnt - wr0), 128'(0));
`endif
    FifoBase = 32'h0;
    FifoEnd  = 32'hFFFF_0000;

    // Reset during beat 2 of a burst, then a clean burst
    wb = w_cnt; n = 0;
    for (int k = 1; k <= 8; k++) store(32'h40 + 32'(k));
    while ((w_cnt - wb) < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("t6_reach_beat2_timeout", 128'(n < 50), 128'(1));
    chk("t6_wvalid_beat2", 128'(axi_if.WVALID), 128'(1));
    resetn = 1'b0;
    #1;
    chk("t6_outs_zero", 128'(|{CPUStall, WritePtr, Wrapped, BusError, Busy,
                               axi_if.AWADDR, axi_if.AWLEN, axi_if.AWSIZE,
                               axi_if.AWBURST, axi_if.AWVALID, axi_if.WDATA,
                               axi_if.WSTRB, axi_if.WLAST, axi_if.WVALID,
                               axi_if.BREADY}), 128'(0));
    tick();
    tick();
    resetn = 1'b1;
    tick();
    load_ptr(32'h4000);
    ab = aw_cnt; wb = w_cnt;
    for (int k = 1; k <= 8; k++) store(32'h50 + 32'(k));
    wait_idle("t6_idle_timeout");
    chk("t6_bursts", 128'(aw_cnt - ab), 128'(1));
    chk("t6_awaddr", 128'(aw_addr_log[ab]), 128'(32'h4000));
    chk("t6_beat0", 128'(w_data_log[wb]), 128'(64'h00000052_00000051));
    chk("t6_beats", 128'(w_cnt - wb), 128'(4));
    chk("t6_writeptr", 128'(WritePtr), 128'(32'h4020));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/write_gather_pipe.md
# write_gather_pipe

Parametrised write-gather pipe for the Flipper CPU-to-GX command path. Packs single-word CPU stores into burst-sized lines, queues up to DEPTH completed lines, and drains each as one AXI4 INCR write burst into a circular memory FIFO bounded by software-programmed base/end registers. Sits between the CPU write port and the system AXI interconnect. Supersedes the fixed 32-byte, single-line gather port.

## Interface
Parameters:
- AXI_ADDR_W, 32, AXI address width
- AXI_DATA_W, 64, AXI write data width (32, 64 or 128)
- BURST_BYTES, 32, bytes per gathered line (power of two, ≥ AXI_DATA_W/8)
- DEPTH, 4, committed lines buffered (power of two, ≥ 2)

Ports (one clock; reset is asynchronous and active-low, `clk` and `resetn`):
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- CPUWriteData  in  32  store data
- CPUWrite  in  1  store strobe, one word per cycle
- CPUStall  out  1  buffer full; strobes while high are dropped
- Flush  in  1  pulse: zero-pad and commit the partial line
- FifoBase, FifoEnd  in  AXI_ADDR_W  circular region, BURST_BYTES-aligned, end exclusive
- WritePtrLoad  in  1  load WritePtrIn into write pointer (honoured only when Busy low)
- WritePtrIn  in  AXI_ADDR_W  new write pointer
- WritePtr  out  AXI_ADDR_W  current memory write pointer
- Wrapped  out  1  one-cycle pulse on pointer wrap
- BusError  out  1  sticky; set on BRESP≠OKAY, cleared by WritePtrLoad
- Busy  out  1  partial line, committed lines, or burst in flight
- AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out, AWREADY  in  AXI write address
- WDATA/WSTRB/WLAST/WVALID  out, WREADY  in  AXI write data
- BRESP[1:0]/BVALID  in, BREADY  out  AXI write response

## Operation
- WORDS = BURST_BYTES/4; BEATS = BURST_BYTES·8/AXI_DATA_W; AWLEN = BEATS−1; AWSIZE = log2(AXI_DATA_W/8); AWBURST = INCR; WSTRB all ones.
- Buffer: DEPTH slots, head/tail pointers, count 0..DEPTH. Accepted store writes the word at tail slot, index `widx`, little-endian word order within beat. `widx` = WORDS−1 on write → commit: tail++, count++, widx←0.
- CPUStall = (count == DEPTH). Dropped stores change no state.
- Flush with widx≠0: remaining words zero, commit next cycle. Flush with widx=0 ignored. Flush coincident with store: store lands first, then pad.
- Drain FSM: IDLE → ADDR (count>0; AWVALID, AWADDR=WritePtr) → DATA (after AW handshake; BEATS beats, WLAST on last) → RESP (BREADY=1) → IDLE on BVALID: head++, count--, WritePtr += BURST_BYTES, wrap check.
- Commit and retire same cycle: count unchanged.
- WritePtrLoad while Busy: ignored.

## Timing
- Reset: all outputs 0; FSM IDLE; pointers, count, widx, WritePtr 0. Reset mid-burst aborts immediately; interconnect shares the reset.
- Commit edge → AWVALID next cycle when IDLE.
- AWVALID/WVALID held until ready; payload stable while valid.
- Back-to-back: IDLE→ADDR one cycle after B handshake (1-cycle bubble).
- CPUStall deasserts the cycle after retire-driven count decrement.
- Wrapped pulses in the cycle after the retiring B handshake.

## Configuration
- WGP_WRAP_EN defined: after advance, WritePtr ≥ FifoEnd → WritePtr = FifoBase, Wrapped pulses.
- Undefined: WritePtr increments linearly modulo 2^AXI_ADDR_W, Wrapped tied 0, FifoBase/FifoEnd unused.

## Structure
- Package `wgp_pkg`: AXI burst/resp constants (INCR, OKAY), FSM state enum, log2/width helper functions.
- Sub-module `wgp_line_buffer`: DEPTH×BURST_BYTES storage, word write port, beat read port, head/tail/count. Top holds drain FSM, pointer, flags.

## Test plan
- 8 stores 0x00000001..0x00000008, WritePtr=0x1000, AWREADY/WREADY=1 → one burst, AWADDR 0x1000, AWLEN 3, WDATA beat0=0x0000000200000001, WLAST on beat 3; WritePtr 0x1020.
- AWREADY low, 40 stores → CPUStall after 32nd store, stores 33–40 dropped; release → 4 bursts, CPUStall low after first B.
- WRAP_EN, base 0x1000, end 0x1040, ptr 0x1020 → two bursts at 0x1020, 0x1000; Wrapped pulses once.
- 3 stores then Flush → one burst, words 3–7 zero.
- BRESP=SLVERR → BusError set, pointer still advances; WritePtrLoad clears it.
- resetn low during DATA beat 2 → all outputs 0 same cycle; recovers with clean burst after release.
